seg_scan_drv: RTL
=================

Name: seg_scan_drv

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver; successor to the single-digit hex-to-segment stage.
- Latches a packed hex word with per-digit decimal-point, blank and flash masks via a load strobe.
- Applies a new word only at a frame boundary, so a scan never shows a mix of old and new digits.
- Scans the digits with a prescaled counter and drives shared active-low segments plus active-low digit selects; sits between the datapath and the board display.

Parameters:
- DIGITS, 4, number of digits scanned (2..8).
- SCAN_CNT, 50000, clocks per digit slot (>=2).
- BLINK_CNT, 12500000, clocks per blink half-period (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- ld  in  1  load strobe; captures the four inputs below on any cycle it is high.
- hex_data  in  4*DIGITS  digit i = hex_data[4i+3:4i]; digit 0 is rightmost.
- point  in  DIGITS  1 = light decimal point of digit i.
- le  in  DIGITS  1 = blank digit i.
- flash  in  DIGITS  1 = digit i blinks.
- seg  out  8  {a,b,c,d,e,f,g,p}, active-low.
- an  out  DIGITS  digit select, active-low, one-hot-low.
- upd_pend  out  1  a loaded word is waiting for the frame boundary.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears prescaler, digit index idx, blink counter and blink phase to 0, and upd_pend to 0.
  - Active and pending hex/point/flash registers go to 0; active and pending le go to all 1s.
  - Outputs: seg=8'hFF, an=all 1s, frame_done=0.
  - Reset mid-scan or mid-load discards all state; no partial word survives.
- Prescaler: counts 0..SCAN_CNT-1 and wraps. Scan tick = cycle with prescaler==SCAN_CNT-1; on that edge idx advances, wrapping DIGITS-1 -> 0.
- Frame boundary is the tick edge where idx wraps to 0:
  - frame_done=1 for exactly the following cycle.
  - If upd_pend=1, pending registers copy to active and upd_pend clears.
- Load: ld=1 writes pending registers and sets upd_pend.
  - A later ld before the boundary overwrites pending (last write wins).
  - ld on the boundary edge: the transfer uses the pending value held before that edge; the new word goes into pending and upd_pend stays 1, so it applies at the next boundary.
- Blink: counter 0..BLINK_CNT-1 and wraps; phase toggles on wrap. Free-running, independent of scan.
- Digit output: seg/an are registered from the current idx and active registers, so they lag idx by exactly 1 clock.
  - an: bit idx low, all other bits high.
  - Blank condition: le[idx]=1, or (flash[idx]=1 and phase=1). When blanked, seg=8'hFF but an still selects the digit.
  - Otherwise seg[7:1] = decode(hex) and seg[0] = ~point[idx].
- Decode table, abcdefg active-low:
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000

Optional Feature:
- Macro SEG_SCAN_DIM_EN.
- Defined:
  - Adds input dim (2 bits).
  - Each digit slot is split into 4 equal quarters; an is driven low only during the first dim+1 quarters and is all 1s for the rest. seg is unchanged.
  - dim=3 gives full duty; dim=0 gives 25% duty. dim is sampled continuously.
- Undefined: no dim port; full duty always.

Test Plan:
All scenarios use DIGITS=4, SCAN_CNT=4, BLINK_CNT=16.
1. Reset then idle for 40 clocks -> seg=8'hFF throughout; an cycles 1110,1101,1011,0111 with each value held 4 clocks; frame_done pulses every 16 clocks.
2. ld with hex_data=16'h3A0F, point=4'b0100, le=0, flash=0, mid-frame -> upd_pend=1 until the next boundary, then 0.
   - Next frame: digit0 seg=8'b01110001, digit1 8'b00000011, digit2 8'b00010000, digit3 8'b00001101.
3. flash=4'b0001 with data as in scenario 2 -> digit0 seg alternates between 8'b01110001 and 8'hFF every 16 clocks; digits 1..3 stay steady.
4. ld with 16'h1111 on the exact boundary edge while 16'h2222 is pending -> 2222 is shown this frame, 1111 the next; upd_pend stays high across the edge.
5. rst_n pulled low for one cycle mid-frame with data displayed -> next cycle seg=8'hFF, an=1111, upd_pend=0; the display stays blank until a new ld and boundary.
6. With SEG_SCAN_DIM_EN and dim=1 -> each digit's an bit is low for 2 of its 4 clocks, high for the other 2.

Source files
------------

// File: rtl/seg_scan_drv.sv
// ============================================================================
// Module   : seg_scan_drv
// Brief    : Time-multiplexed multi-digit 7-segment driver with frame-aligned
//            word update, per-digit blank/flash/point. Optional macro
//            SEG_SCAN_DIM_EN adds a 2-bit dim input for quarter-slot duty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_scan_drv #(
    parameter int DIGITS    = 4,
    parameter int SCAN_CNT  = 50000,
    parameter int BLINK_CNT = 12500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   hex_data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     le,
    input  logic [DIGITS-1:0]     flash,
`ifdef SEG_SCAN_DIM_EN
    input  logic [1:0]            dim,
`endif
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  upd_pend,
    output logic                  frame_done
);

    localparam int c_pw = $clog2(SCAN_CNT);
    localparam int c_bw = $clog2(BLINK_CNT);
    localparam int c_iw = $clog2(DIGITS);

    localparam logic [c_pw-1:0] c_pre_last   = c_pw'(SCAN_CNT - 1);
    localparam logic [c_bw-1:0] c_blink_last = c_bw'(BLINK_CNT - 1);
    localparam logic [c_iw-1:0] c_idx_last   = c_iw'(DIGITS - 1);

    logic [c_pw-1:0]       r_pre;
    logic [c_iw-1:0]       r_idx;
    logic [c_bw-1:0]       r_blink;
    logic                  r_phase;
    logic                  r_upd_pend;
    logic                  r_frame_done;
    logic [7:0]            r_seg;
    logic [DIGITS-1:0]     r_an;

    logic [4*DIGITS-1:0]   r_pnd_hex, r_act_hex;
    logic [DIGITS-1:0]     r_pnd_pt,  r_act_pt;
    logic [DIGITS-1:0]     r_pnd_le,  r_act_le;
    logic [DIGITS-1:0]     r_pnd_fl,  r_act_fl;

    logic                  w_tick;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic                  w_blank;
    logic                  w_duty_on;
    logic [DIGITS-1:0]     w_sel;

    function automatic logic [6:0] f_dec(input logic [3:0] h);
        logic [6:0] v;
        case (h)
            4'h0: v = 7'b0000001;
            4'h1: v = 7'b1001111;
            4'h2: v = 7'b0010010;
            4'h3: v = 7'b0000110;
            4'h4: v = 7'b1001100;
            4'h5: v = 7'b0100100;
            4'h6: v = 7'b0100000;
            4'h7: v = 7'b0001111;
            4'h8: v = 7'b0000000;
            4'h9: v = 7'b0000100;
            4'hA: v = 7'b0001000;
            4'hB: v = 7'b1100000;
            4'hC: v = 7'b0110001;
            4'hD: v = 7'b1000010;
            4'hE: v = 7'b0110000;
            default: v = 7'b0111000;
        endcase
        return v;
    endfunction

    assign w_tick  = (r_pre == c_pre_last);
    assign w_wrap  = w_tick && (r_idx == c_idx_last);
    assign w_nib   = r_act_hex[{r_idx, 2'b00} +: 4];
    assign w_blank = r_act_le[r_idx] || (r_act_fl[r_idx] && r_phase);
    assign w_sel   = ~(DIGITS'(1) << r_idx);

`ifdef SEG_SCAN_DIM_EN
    // Lit while prescaler sits in the first dim+1 quarters of the slot.
    assign w_duty_on = ((32'(r_pre) * 32'd4) < ((32'(dim) + 32'd1) * 32'(SCAN_CNT)));
`else
    assign w_duty_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_blink      <= '0;
            r_phase      <= 1'b0;
            r_upd_pend   <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg        <= 8'hFF;
            r_an         <= '1;
            r_pnd_hex    <= '0;
            r_act_hex    <= '0;
            r_pnd_pt     <= '0;
            r_act_pt     <= '0;
            r_pnd_le     <= '1;
            r_act_le     <= '1;
            r_pnd_fl     <= '0;
            r_act_fl     <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end

            if (r_blink == c_blink_last) begin
                r_blink <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_blink <= r_blink + 1'b1;
            end

            r_frame_done <= w_wrap;

            // Transfer reads the pending word as it stood before this edge.
            if (w_wrap && r_upd_pend) begin
                r_act_hex <= r_pnd_hex;
                r_act_pt  <= r_pnd_pt;
                r_act_le  <= r_pnd_le;
                r_act_fl  <= r_pnd_fl;
            end

            if (ld) begin
                r_pnd_hex  <= hex_data;
                r_pnd_pt   <= point;
                r_pnd_le   <= le;
                r_pnd_fl   <= flash;
                r_upd_pend <= 1'b1;
            end else if (w_wrap) begin
                r_upd_pend <= 1'b0;
            end

            r_seg <= w_blank ? 8'hFF : {f_dec(w_nib), ~r_act_pt[r_idx]};
            r_an  <= w_duty_on ? w_sel : '1;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign upd_pend   = r_upd_pend;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire
